// File: rtl/abcd_vector_sequencer.sv
// rtl/abcd_vector_sequencer.sv - sweeps the 16 {A,B,C,D} input codes with a programmable hold time
//
// Purpose: stimulus generator for the combinational E,F stage. A start
// launches one sweep of all 16 input codes in binary or Gray order. Each code
// is held for HOLD_CYCLES clocks. A sample strobe marks the last cycle of each
// hold window, and done pulses once after the final code.
//
// Ports:
//   clock      rising-edge clock
//   reset_b    asynchronous active-low reset
//   start      launches a sweep when the sequencer is not running
//   mode       sweep order, 0 = binary, 1 = Gray; captured when start is accepted
//   A,B,C,D    registered stimulus bits, A is the MSB of the code
//   index      sweep position 0..15 of the applied code
//   vec_valid  high while a sweep code is driven on A..D
//   sample     high in the last hold cycle of each code
//   busy       high while sweeping
//   done       one-cycle pulse after the last code completes
module abcd_vector_sequencer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic       clock,
    input  logic       reset_b,
    input  logic       start,
    input  logic       mode,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic [3:0] index,
    output logic       vec_valid,
    output logic       sample,
    output logic       busy,
    output logic       done
);

    // The counter only has to reach HOLD_CYCLES-1, so H=256 fits in 8 bits.
    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    // With a one-cycle hold, every RUN cycle is also the sample cycle.
    localparam logic SINGLE = (HOLD_CYCLES == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic          mode_q;

    function automatic logic [3:0] code_of(input logic [3:0] idx, input logic gray);
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            mode_q       <= 1'b0;
            {A, B, C, D} <= 4'd0;
            index        <= 4'd0;
            vec_valid    <= 1'b0;
            sample       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (index != 4'd15) begin
                            index        <= index + 4'd1;
                            hold_cnt     <= '0;
                            {A, B, C, D} <= code_of(index + 4'd1, mode_q);
                            sample       <= SINGLE;
                        end else begin
                            state        <= S_FINISH;
                            hold_cnt     <= '0;
                            index        <= 4'd0;
                            {A, B, C, D} <= 4'd0;
                            vec_valid    <= 1'b0;
                            sample       <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                        // sample is registered, so it is raised as the counter
                        // moves onto its last value.
                        sample   <= ((hold_cnt + HOLD_ONE) == HOLD_LAST);
                    end
                end
                default: begin
                    // IDLE and FINISH both accept start. A start held high
                    // through FINISH is taken on the edge that would otherwise
                    // return to IDLE, so back-to-back sweeps have no gap cycle.
                    done <= 1'b0;
                    if (start) begin
                        state        <= S_RUN;
                        index        <= 4'd0;
                        hold_cnt     <= '0;
                        mode_q       <= mode;
                        {A, B, C, D} <= 4'd0;
                        vec_valid    <= 1'b1;
                        sample       <= SINGLE;
                        busy         <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abcd_vector_sequencer.sv
// tb/tb_abcd_vector_sequencer.sv - self-checking bench for abcd_vector_sequencer (H=4 and H=1)
module tb_abcd_vector_sequencer;

    logic clock = 1'b0;
    logic reset_b = 1'b0;
    logic start4 = 1'b0, mode4 = 1'b0;
    logic start1 = 1'b0, mode1 = 1'b0;

    logic a4, b4, c4, d4, vv4, smp4, bsy4, dn4;
    logic [3:0] idx4;
    logic a1, b1, c1, d1, vv1, smp1, bsy1, dn1;
    logic [3:0] idx1;

    always #5 clock = ~clock;

    abcd_vector_sequencer #(.HOLD_CYCLES(4)) dut4 (
        .clock(clock), .reset_b(reset_b), .start(start4), .mode(mode4),
        .A(a4), .B(b4), .C(c4), .D(d4), .index(idx4),
        .vec_valid(vv4), .sample(smp4), .busy(bsy4), .done(dn4)
    );

    abcd_vector_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clock(clock), .reset_b(reset_b), .start(start1), .mode(mode1),
        .A(a1), .B(b1), .C(c1), .D(d1), .index(idx1),
        .vec_valid(vv1), .sample(smp1), .busy(bsy1), .done(dn1)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t = cycles since the accepting edge, -1 when idle.
    // 0..16H-1 is the sweep, 16H is the done cycle.
    int   m4_t = -1, m1_t = -1;
    logic m4_md = 1'b0, m1_md = 1'b0;

    function automatic int next_t(input int t, input int h, input logic st);
        if (t >= 0 && t < 16 * h) return t + 1;
        return st ? 0 : -1;
    endfunction

    // Packed as {A,B,C,D, index, vec_valid, sample, busy, done}.
    function automatic logic [11:0] expect_out(input int t, input logic md, input int h);
        int k;
        logic [3:0] kk, code;
        if (t < 0) return 12'd0;
        if (t == 16 * h) return 12'd1;
        k = t / h;
        kk = k[3:0];
        code = md ? (kk ^ (kk >> 1)) : kk;
        return {code, kk, 1'b1, (t % h == h - 1), 1'b1, 1'b0};
    endfunction

    always @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            m4_t <= -1; m1_t <= -1; m4_md <= 1'b0; m1_md <= 1'b0;
        end else begin
            if ((m4_t < 0 || m4_t == 64) && start4) m4_md <= mode4;
            if ((m1_t < 0 || m1_t == 16) && start1) m1_md <= mode1;
            m4_t <= next_t(m4_t, 4, start4);
            m1_t <= next_t(m1_t, 1, start1);
        end
    end

    always @(negedge clock) begin
        check("dut4_outputs", int'({a4, b4, c4, d4, idx4, vv4, smp4, bsy4, dn4}),
              int'(expect_out(m4_t, m4_md, 4)));
        check("dut1_outputs", int'({a1, b1, c1, d1, idx1, vv1, smp1, bsy1, dn1}),
              int'(expect_out(m1_t, m1_md, 1)));
    end

    logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    logic [3:0] codes [$];
    int last_idx, dcount, dat, scount, run, maxrun, found;

    task automatic collect_codes();
        if (vv4 && int'(idx4) != last_idx) begin
            codes.push_back({a4, b4, c4, d4});
            last_idx = int'(idx4);
        end
    endtask

    initial begin
        #3;
        check("reset_dut4", int'({a4, b4, c4, d4, idx4, vv4, smp4, bsy4, dn4}), 0);
        check("reset_dut1", int'({a1, b1, c1, d1, idx1, vv1, smp1, bsy1, dn1}), 0);
        @(negedge clock);
        reset_b = 1'b1;
        @(negedge clock);

        // Binary sweep, H=4, with extra start pulses at E0+10 and E0+63.
        start4 = 1'b1; mode4 = 1'b0;
        dcount = 0; dat = -1; scount = 0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clock);
            start4 = (i == 10 || i == 63);
            if (dn4) begin dcount++; dat = i - 1; end
            if (smp4) scount++;
        end
        check("bin_done_count", dcount, 1);
        check("bin_done_cycle", dat, 64);
        check("bin_sample_count", scount, 16);
        check("bin_busy_after", int'(bsy4), 0);

        // Gray sweep.
        @(negedge clock);
        start4 = 1'b1; mode4 = 1'b1;
        codes.delete(); last_idx = -1;
        for (int i = 1; i <= 68; i++) begin
            @(negedge clock);
            start4 = 1'b0;
            collect_codes();
        end
        check("gray_code_count", codes.size(), 16);
        for (int k = 0; k < codes.size() && k < 16; k++) check("gray_code", int'(codes[k]), int'(gray_tab[k]));
        for (int k = 1; k < codes.size(); k++) check("gray_one_toggle", $countones(codes[k] ^ codes[k-1]), 1);

        // Mode flipped to Gray at E0+5 must not affect a binary sweep.
        @(negedge clock);
        start4 = 1'b1; mode4 = 1'b0;
        codes.delete(); last_idx = -1;
        for (int i = 1; i <= 68; i++) begin
            @(negedge clock);
            start4 = 1'b0;
            if (i == 5) mode4 = 1'b1;
            collect_codes();
        end
        mode4 = 1'b0;
        check("modeflip_code_count", codes.size(), 16);
        for (int k = 0; k < codes.size() && k < 16; k++) check("modeflip_code", int'(codes[k]), k);

        // Reset asserted between edges while index 7 is applied.
        @(negedge clock);
        start4 = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clock);
            start4 = 1'b0;
            if (idx4 == 4'd7) found = 1;
        end
        check("reached_index7", found, 1);
        #2 reset_b = 1'b0;
        #1 check("reset_midsweep", int'({a4, b4, c4, d4, idx4, vv4, smp4, bsy4, dn4}), 0);
        dcount = 0;
        repeat (3) begin
            @(negedge clock);
            if (dn4) dcount++;
        end
        reset_b = 1'b1;
        repeat (2) begin
            @(negedge clock);
            if (dn4) dcount++;
        end
        check("reset_no_done", dcount, 0);
        start4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
        check("restart_index", int'(idx4), 0);
        check("restart_code", int'({a4, b4, c4, d4}), 0);
        check("restart_valid", int'(vv4), 1);
        repeat (70) @(negedge clock);

        // H=1 with start held high: back-to-back sweeps.
        start1 = 1'b1;
        run = 0; maxrun = 0; dat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 20) start1 = 1'b0;
            run = smp1 ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (dn1 && dat < 0) dat = i - 1;
            if (i == 18) begin
                check("h1_second_index", int'(idx1), 0);
                check("h1_second_code", int'({a1, b1, c1, d1}), 0);
                check("h1_second_busy", int'(bsy1), 1);
            end
        end
        check("h1_sample_run", maxrun, 16);
        check("h1_done_cycle", dat, 16);
        check("h1_idle_after", int'(bsy1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
